// File: rtl/cv32e40n_data_mem_responder.sv
// OBI-style data-bus responder with an internal byte-writable word memory.
// Every accepted transaction gets exactly one in-order rvalid after a fixed
// RVALID_LATENCY. Reads capture memory at the accept edge. Writes answer with
// rdata = 0.
// Optional feature: define CV32E40N_DATA_MEM_RANDOM_STALL_EN to add an
// LFSR-driven random grant stall. The stall exercises request holding in the
// crossbar.
module cv32e40n_data_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem_q   [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             unused_addr;
  logic             stall;
  logic             full;
  logic             accept;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             valid_q [RVALID_LATENCY];
  logic             valid_d [RVALID_LATENCY];
  logic [31:0]      rdata_q [RVALID_LATENCY];
  logic [31:0]      rdata_d [RVALID_LATENCY];

  // Upper address bits and the byte offset are ignored, so addresses alias.
  assign idx         = data_addr_i[IDX_W+1:2];
  assign unused_addr = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0]};

`ifdef CV32E40N_DATA_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR advances every cycle and is re-seeded on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A retire in the same cycle does not free a slot early.
  assign full       = (cnt_q == 4'(MAX_OUTSTANDING));
  assign data_gnt_o = data_req_i & ~full & ~stall & ~rst_i;
  assign accept     = data_gnt_o;

  // Byte-enabled write on accept. The array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 loads on accept, and later stages shift.
  // An empty stage carries zero data, so rdata is 0 whenever rvalid is 0.
  generate
    for (genvar gi = 0; gi < RVALID_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_d[gi] = accept;
        assign rdata_d[gi] = (accept && !data_we_i) ? mem_q[idx] : 32'h0;
      end else begin : g_tail
        assign valid_d[gi] = valid_q[gi-1];
        assign rdata_d[gi] = rdata_q[gi-1];
      end
    end
  endgenerate

  // Outstanding count: +1 on accept, -1 on retire; both at once cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !data_rvalid_o) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!accept && data_rvalid_o) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Pipeline and counter registers. Reset drops all in-flight responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
      for (int s = 0; s < int'(RVALID_LATENCY); s++) begin
        valid_q[s] <= 1'b0;
        rdata_q[s] <= 32'h0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int s = 0; s < int'(RVALID_LATENCY); s++) begin
        valid_q[s] <= valid_d[s];
        rdata_q[s] <= rdata_d[s];
      end
    end
  end

  assign data_rvalid_o = valid_q[RVALID_LATENCY-1];
  assign data_rdata_o  = rdata_q[RVALID_LATENCY-1];
  assign outstanding_o = cnt_q;

  // A response always belongs to an outstanding transaction
  a_rvalid_needs_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) data_rvalid_o |-> (cnt_q != 4'd0));

  // No grant while the outstanding limit is reached
  a_no_gnt_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i) data_gnt_o |-> !full);

endmodule
